// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the issuing pipeline stage and the multiply/divide unit.
// The issuing stage is the master; the unit is the slave.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (MULTU, MULT, DIVU, DIV, MTHI, MTLO).
// One shift-add or restoring shift-subtract step per clock; the result lands 33 edges after start.
module mul_div_unit (
    input  logic             clk,
    input  logic             rst_n,
    mul_div_unit_if.slave    bus,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a valid-only request, accepted on any edge where the FSM is IDLE
    // (busy low, including the cycle done is high); a start seen while busy is dropped, never queued.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  count;
    logic        is_div;
    logic        neg_lo;
    logic        neg_hi;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        b_zero;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] acc_step;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign accept    = (state == IDLE) && bus.start;
    assign is_signed = bus.op[0];
    assign a_neg     = is_signed & bus.operand_a[31];
    assign b_neg     = is_signed & bus.operand_b[31];
    assign a_mag     = a_neg ? (32'd0 - bus.operand_a) : bus.operand_a;
    assign b_mag     = b_neg ? (32'd0 - bus.operand_b) : bus.operand_b;
    assign b_zero    = (bus.operand_b == 32'd0);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = CALC;
            CALC:    if (count == 6'd31) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Multiply: acc = {partial, multiplier}; the multiplier bit under test is acc[0].
    // Divide:   acc = {remainder, dividend/quotient}; quotient bits shift in from the right.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_shift[31:0] - opnd;
        acc_step  = acc;
        if (is_div) begin
            acc_step = {(div_ge ? div_rem : div_shift[31:0]), acc[30:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    // Divide by zero leaves quotient all ones and remainder = |a|; neg_lo is cleared for it
    // at capture so only the remainder picks up the dividend's sign, which restores operand_a.
    always_comb begin
        prod_fix = neg_lo ? (64'd0 - acc) : acc;
        quo_fix  = neg_lo ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != IDLE);
            done_q <= (state == FINISH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 6'd0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            opnd   <= 32'd0;
            acc    <= 64'd0;
        end else begin
            if (accept) begin
                count  <= 6'd0;
                is_div <= bus.op[1];
                if (bus.op[1]) begin
                    neg_lo <= (a_neg ^ b_neg) & ~b_zero;
                    neg_hi <= a_neg;
                    opnd   <= b_mag;
                    acc    <= {32'd0, a_mag};
                end else begin
                    neg_lo <= a_neg ^ b_neg;
                    neg_hi <= 1'b0;
                    opnd   <= a_mag;
                    acc    <= {32'd0, b_mag};
                end
            end else if (state == CALC) begin
                count <= (count == 6'd31) ? 6'd0 : count + 6'd1;
                acc   <= acc_step;
            end
        end
    end

    // Only the FINISH edge or an IDLE move-to write may touch HI/LO; start takes priority over MT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (state == FINISH) begin
            if (is_div) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else begin
                hi_q <= prod_fix[63:32];
                lo_q <= prod_fix[31:0];
            end
        end else if ((state == IDLE) && !bus.start) begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: a cycle-level reference model checked every cycle,
// plus hand-computed literal results for the listed corner cases.
module tb_mul_div_unit;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} straight from the instruction definitions.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa   = a;
        sb   = b;
        case (o)
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_MULT:  return sa64 * sb64;
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    // Reference timeline: an accepted start produces its result 33 edges later.
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_res;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_res  <= 64'd0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy <= 1'b1;
                    m_left <= 33;
                    m_res  <= model(bus.op, bus.operand_a, bus.operand_b);
                end else begin
                    if (bus.hi_we) m_hi <= bus.wdata;
                    if (bus.lo_we) m_lo <= bus.wdata;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {63'd0, bus.busy}, {63'd0, m_busy});
            check("done", {63'd0, bus.done}, {63'd0, m_done});
            check("hi", {32'd0, bus.hi}, {32'd0, m_hi});
            check("lo", {32'd0, bus.lo}, {32'd0, m_lo});
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        bit got;
        got = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_cycles++;
                @(negedge clk);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int bc;
        start_op(o, a, b);
        wait_done(bc);
        check({name, "_busy_cycles"}, 64'(bc), 64'd33);
        check({name, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check({name, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    endtask

    initial begin
        int bc;
        int dones;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        rst_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        check("multu_done_pulse_width", {63'd0, bus.done}, 64'd0);
        run_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("div_zero_neg", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999);

        // MTHI in IDLE
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_hi", {32'd0, bus.hi}, 64'h1234);
        check("mthi_no_done", {63'd0, bus.done}, 64'd0);

        // start and MTLO on the same edge: start wins
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        start_op(OP_MULTU, 32'd3, 32'd5);
        bus.lo_we = 1'b0;
        wait_done(bc);
        check("start_vs_mtlo_lo", {32'd0, bus.lo}, 64'd15);
        check("start_vs_mtlo_hi", {32'd0, bus.hi}, 64'd0);

        // restart and MTHI while busy are both ignored
        start_op(OP_DIVU, 32'd100, 32'd7);
        dones  = 0;
        got_hi = 32'd0;
        got_lo = 32'd0;
        for (int c = 1; c <= 45; c++) begin
            bus.start     = (c == 5);
            bus.op        = OP_MULTU;
            bus.operand_a = 32'd9;
            bus.operand_b = 32'd9;
            bus.hi_we     = (c == 10);
            bus.wdata     = 32'hABCD;
            @(negedge clk);
            if (bus.done) begin
                dones++;
                got_hi = bus.hi;
                got_lo = bus.lo;
            end
        end
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("busy_ignore_done_count", 64'(dones), 64'd1);
        check("busy_ignore_lo", {32'd0, got_lo}, 64'd14);
        check("busy_ignore_hi", {32'd0, got_hi}, 64'd2);

        // back-to-back: new start issued in the done cycle
        start_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(bc);
        check("b2b_first_lo", {32'd0, bus.lo}, 64'hFFFFFFFD);
        check("b2b_first_hi", {32'd0, bus.hi}, 64'd1);
        run_op("b2b_second", OP_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0);

        // reset in the middle of CALC
        start_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_multu", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters SHALL be none; operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled on the rising edge.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 operand_a  input  32  multiplicand or dividend (rs).
REQ-007 operand_b  input  32  multiplier or divisor (rt).
REQ-008 hi_we  input  1  MTHI write strobe.
REQ-009 lo_we  input  1  MTLO write strobe.
REQ-010 wdata  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  operation in progress; the issuing stage stalls MFHI/MFLO while high.
REQ-012 done  output  1  one-cycle pulse in the first cycle new HI/LO are visible.
REQ-013 hi  output  32  HI register; feeds register-file WriteData on MFHI.
REQ-014 lo  output  32  LO register; feeds register-file WriteData on MFLO.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC, and FINISH.
REQ-016 In IDLE, start=1 SHALL capture op, operand_a, and operand_b and move the FSM to CALC.
REQ-017 The unit SHALL convert signed operands (op 01/11) to magnitudes at capture and record the result signs.
REQ-018 CALC SHALL run exactly 32 iterations, one per clock: shift-add for multiply, restoring shift-subtract for divide; a 6-bit counter SHALL count 0..31.
REQ-019 On the edge where the counter reaches 31, the FSM SHALL go to FINISH.
REQ-020 The FINISH edge SHALL apply sign correction, write HI/LO, and return the FSM to IDLE.
REQ-021 Latency: with start sampled at edge E0, HI/LO SHALL update at edge E33 and done SHALL be high during the cycle after E33.
REQ-022 busy SHALL be 1 from after E0 until E33 and 0 after E33.
REQ-023 busy SHALL be a registered output derived from state != IDLE.
REQ-024 Multiply SHALL produce {hi,lo} as the full 64-bit product, unsigned for MULTU and two's-complement for MULT.
REQ-025 Divide SHALL produce lo = quotient and hi = remainder; signed quotient SHALL truncate toward zero and the signed remainder SHALL take the dividend's sign.
REQ-026 Divide by zero (DIVU or DIV) SHALL produce lo=32'hFFFFFFFF and hi=operand_a, with full latency.
REQ-027 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce lo=32'h80000000 and hi=0.
REQ-028 start while busy SHALL be ignored, with no queueing.
REQ-029 hi_we/lo_we while busy SHALL be ignored, and HI/LO SHALL hold their old values throughout CALC.
REQ-030 In IDLE without start, hi_we SHALL load hi<=wdata and lo_we SHALL load lo<=wdata on the next edge; both strobes may fire together.
REQ-031 If start and hi_we/lo_we are sampled on the same edge in IDLE, start SHALL win and the MT write SHALL be dropped.
REQ-032 done SHALL never be asserted by MTHI/MTLO writes.
REQ-033 A new start SHALL be accepted in the cycle that done is high (back-to-back operation).

Reset
REQ-034 While rst_n=0, asynchronously: state SHALL be IDLE, counter 0, busy 0, done 0, hi 0, lo 0, and internal datapath registers 0.
REQ-035 Reset asserted mid-CALC SHALL abort the operation, and no done pulse SHALL follow.
REQ-036 After rst_n deasserts, the first rising edge SHALL accept start.

Verification
REQ-037 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy high for 33 cycles, then hi=32'hFFFFFFFE, lo=32'h00000001, done pulse of one cycle.
REQ-038 MULT a=-2, b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-039 DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5 after 33 cycles; DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
REQ-040 MTHI 32'h1234 in IDLE -> hi=32'h1234 next cycle, done stays 0; start plus lo_we on the same edge -> lo reflects only the operation result.
REQ-041 Start DIVU 100/7, pulse start again at cycle 5 and hi_we at cycle 10 -> both ignored; result lo=14, hi=2, exactly one done pulse.
REQ-042 Start MULT, assert rst_n=0 at cycle 10 of CALC -> busy, done, hi, and lo all 0 immediately; a fresh MULTU 3*4 afterwards gives lo=12, hi=0.
